// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: ALU passthrough, load/store access to dmem, writeback pulse
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_valid / ex_ready         handshake from execute stage
//   ex_alu_out, ex_rs2_data     result or effective address, store data
//   ex_rd, ex_reg_write         destination register and write enable
//   ex_mem_read, ex_mem_write   memory op flags
//   ex_funct3                   access size/sign
//   dmem_req/we/addr/wdata/wstrb  data memory request (held until dmem_ready)
//   dmem_ready, dmem_rdata      data memory completion and read data
//   wb_valid, wb_reg_write, wb_fault, wb_rd, wb_data  one-cycle writeback result
module mem_stage #(
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_fault,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int CW = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(DMEM_TIMEOUT);

    state_t state, state_next;
    logic [CW-1:0] tcnt;

    // Attributes of the in-flight access, needed when the response arrives
    logic [2:0]  acc_funct3;
    logic [1:0]  acc_off;
    logic        acc_load;
    logic [4:0]  acc_rd;
    logic        acc_rw;

    logic        accept;
    logic        is_mem;
    logic        legal_f3;
    logic        misalign;
    logic        mem_fault;
    logic        done;
    logic        timeout;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ex_ready   = (state == IDLE) && rst_n;
        accept     = ex_valid && ex_ready;
        is_mem     = ex_mem_read || ex_mem_write;

        // A set read flag takes priority, so an op with both flags is a load
        if (ex_mem_read) begin
            legal_f3 = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                       (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
        end else begin
            legal_f3 = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
        end
        misalign  = ((ex_funct3[1:0] == 2'b01) && ex_alu_out[0]) ||
                    ((ex_funct3[1:0] == 2'b10) && (ex_alu_out[1:0] != 2'b00));
        mem_fault = !legal_f3 || misalign;

        done    = (state == ACCESS) && dmem_ready;
        // Fires on the cycle whose miss brings the count up to the limit; dmem_ready has priority
        timeout = (state == ACCESS) && !dmem_ready && (DMEM_TIMEOUT != 0) &&
                  ((tcnt + CW'(1)) == TMAX);

        case (state)
            IDLE:    if (accept && is_mem && !mem_fault) state_next = ACCESS;
            ACCESS:  if (done || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        st_wstrb = 4'b1111;
        st_wdata = ex_rs2_data;
        case (ex_funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << ex_alu_out[1:0];
                st_wdata = {4{ex_rs2_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << ex_alu_out[1:0];
                st_wdata = {2{ex_rs2_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = ex_rs2_data;
            end
        endcase

        ld_byte = dmem_rdata[8*acc_off +: 8];
        ld_half = acc_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (acc_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt         <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            dmem_wstrb   <= 4'd0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            acc_funct3   <= 3'd0;
            acc_off      <= 2'd0;
            acc_load     <= 1'b0;
            acc_rd       <= 5'd0;
            acc_rw       <= 1'b0;
        end else begin
            // Writeback strobes are single-cycle; data/rd simply hold
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;

            if (state == IDLE) begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ex_alu_out;
                        wb_rd        <= ex_rd;
                        wb_reg_write <= ex_reg_write && (ex_rd != 5'd0);
                    end else if (mem_fault) begin
                        wb_valid <= 1'b1;
                        wb_fault <= 1'b1;
                        wb_data  <= 32'd0;
                        wb_rd    <= ex_rd;
                    end else begin
                        tcnt       <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= !ex_mem_read;
                        dmem_addr  <= {ex_alu_out[31:2], 2'b00};
                        dmem_wdata <= ex_mem_read ? 32'd0 : st_wdata;
                        dmem_wstrb <= ex_mem_read ? 4'd0 : st_wstrb;
                        acc_funct3 <= ex_funct3;
                        acc_off    <= ex_alu_out[1:0];
                        acc_load   <= ex_mem_read;
                        acc_rd     <= ex_rd;
                        acc_rw     <= ex_reg_write && (ex_rd != 5'd0);
                    end
                end
            end else begin
                if (done || timeout) begin
                    dmem_req   <= 1'b0;
                    dmem_we    <= 1'b0;
                    dmem_wstrb <= 4'd0;
                    wb_valid   <= 1'b1;
                    wb_rd      <= acc_rd;
                end
                if (done) begin
                    wb_data      <= acc_load ? ld_data : 32'd0;
                    wb_reg_write <= acc_load && acc_rw;
                end else if (timeout) begin
                    wb_fault <= 1'b1;
                    wb_data  <= 32'd0;
                end else begin
                    tcnt <= tcnt + CW'(1);
                end
            end
        end
    end

endmodule
